seg_scan_ctrl: RTL

- Multiplexed-display scan controller for a 4-digit seven-segment display.
- Its 2-bit digit-select output `sel` drives the 2-to-4 digit decoder directly; that decoder produces the one-hot digit-enable.
- The block holds a 16-bit display value (four hex nibbles) and advances the scan at a prescaled rate.
- It presents the current digit's nibble, decimal point and blank flag to the segment encoder.
- New values are double-buffered so that only whole frames are displayed (no tearing).

---
 rtl/seg_scan_ctrl_if.sv | 25 ++
 rtl/seg_scan_ctrl.sv | 87 ++++++++
 2 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of scan-controller control inputs and display-side outputs.
// The controller binds to slave; the driver of load/value/en binds to master.
interface seg_scan_ctrl_if;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [1:0]  sel;
    logic [3:0]  nibble;
    logic        dp;
    logic        blank;
    logic        pending;
    logic        frame_done;

    modport master (
        output en, load, value, dp_mask, lz_blank,
        input  sel, nibble, dp, blank, pending, frame_done
    );

    modport slave (
        input  en, load, value, dp_mask, lz_blank,
        output sel, nibble, dp, blank, pending, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a prescaled scan
// and frame-aligned double buffering of the displayed value.
module seg_scan_ctrl #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned PRE_W    = 17
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int unsigned VAL_W = 16;
    localparam int unsigned DIG_N = 4;

    logic [PRE_W-1:0] pre_cnt;
    logic [1:0]       sel_q;
    logic [VAL_W-1:0] disp_val;
    logic [DIG_N-1:0] disp_dp;
    logic             disp_lz;
    logic [VAL_W-1:0] pend_val;
    logic [DIG_N-1:0] pend_dp;
    logic             pend_lz;
    logic             pend_q;
    logic             frame_done_q;

    logic             tick;
    logic             wrap;
    logic             z3;
    logic             z2;
    logic             z1;
    logic [DIG_N-1:0] lz_off;

    assign tick = bus.en && (pre_cnt == PRE_W'(PRESCALE - 1));
    assign wrap = tick && (sel_q == 2'd3);

    // Scan position, frame pulse and the pending/display buffer pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt      <= '0;
            sel_q        <= '0;
            disp_val     <= '0;
            disp_dp      <= '0;
            disp_lz      <= 1'b0;
            pend_val     <= '0;
            pend_dp      <= '0;
            pend_lz      <= 1'b0;
            pend_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (bus.en) begin
                pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            end
            if (tick) begin
                sel_q <= sel_q + 2'd1;
            end
            frame_done_q <= wrap;
            // Display takes the old pending contents even if a load collides.
            if (wrap && pend_q) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
                disp_lz  <= pend_lz;
            end
            if (bus.load) begin
                pend_val <= bus.value;
                pend_dp  <= bus.dp_mask;
                pend_lz  <= bus.lz_blank;
                pend_q   <= 1'b1;
            end else if (wrap && pend_q) begin
                pend_q <= 1'b0;
            end
        end
    end

    // A digit is blanked when it and every more significant digit are zero.
    always_comb begin
        z3     = (disp_val[15:12] == 4'h0);
        z2     = z3 && (disp_val[11:8] == 4'h0);
        z1     = z2 && (disp_val[7:4] == 4'h0);
        lz_off = {z3, z2, z1, 1'b0} & {DIG_N{disp_lz}};
    end

    assign bus.sel        = sel_q;
    assign bus.nibble     = disp_val[{sel_q, 2'b00} +: 4];
    assign bus.dp         = disp_dp[sel_q];
    assign bus.blank      = ~bus.en | lz_off[sel_q];
    assign bus.pending    = pend_q;
    assign bus.frame_done = frame_done_q;
endmodule
